hamming_serial_receiver: RTL and testbench

HAMMING_SERIAL_RECEIVER -- requirements
Module: hamming_serial_receiver

---
 rtl/hamming_serial_receiver_if.sv | 22 ++
 rtl/hamming_serial_receiver.sv | 98 +++++++++
 tb/tb_hamming_serial_receiver.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hamming_serial_receiver_if.sv
// Serial Hamming(7,4) receive port: bit stream in, decoded nibble and status out.
// master drives shift/serial_in/frame_clr; slave is the receiver.
interface hamming_serial_receiver_if;
  logic       shift;
  logic       serial_in;
  logic       frame_clr;
  logic [3:0] data_out;
  logic       valid;
  logic [2:0] syndrome;
  logic       err_corrected;
  logic       busy;

  modport master (
    output shift, serial_in, frame_clr,
    input  data_out, valid, syndrome, err_corrected, busy
  );

  modport slave (
    input  shift, serial_in, frame_clr,
    output data_out, valid, syndrome, err_corrected, busy
  );
endinterface

// File: rtl/hamming_serial_receiver.sv
// Deserialises LSB-first Hamming(7,4) codewords and decodes them; result is valid one cycle
// after the 7th sampled bit. No backpressure: shift paces the input, valid is a one-cycle pulse.
module hamming_serial_receiver #(
  parameter bit CORRECT_EN = 1'b1
) (
  input  logic                      clk,
  input  logic                      stp_reset,
  hamming_serial_receiver_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECV, DECODE} state_t;

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [6:0] sr_q;
  logic [3:0] data_q;
  logic [2:0] syn_q;
  logic       err_q;
  logic       valid_q;

  logic [2:0] syn_d;
  logic [6:0] fixed_d;

  // sr_q[k] holds codeword bit c(k+1); syndrome value names the failing position directly.
  always_comb begin
    syn_d = {sr_q[3] ^ sr_q[4] ^ sr_q[5] ^ sr_q[6],
             sr_q[1] ^ sr_q[2] ^ sr_q[5] ^ sr_q[6],
             sr_q[0] ^ sr_q[2] ^ sr_q[4] ^ sr_q[6]};
    fixed_d = sr_q;
    if (CORRECT_EN && (syn_d != 3'd0)) begin
      fixed_d = sr_q ^ (7'd1 << (syn_d - 3'd1));
    end
  end

  always_ff @(posedge clk or posedge stp_reset) begin
    if (stp_reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      sr_q    <= 7'd0;
      data_q  <= 4'd0;
      syn_q   <= 3'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.shift) begin
            sr_q    <= {6'd0, bus.serial_in};
            cnt_q   <= 3'd1;
            state_q <= RECV;
          end
        end
        RECV: begin
          if (bus.frame_clr) begin
            sr_q    <= 7'd0;
            cnt_q   <= 3'd0;
            state_q <= IDLE;
          end else if (bus.shift) begin
            sr_q[cnt_q] <= bus.serial_in;
            if (cnt_q == 3'd6) begin
              cnt_q   <= 3'd0;
              state_q <= DECODE;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        DECODE: begin
          data_q  <= {fixed_d[6], fixed_d[5], fixed_d[4], fixed_d[2]};
          syn_q   <= syn_d;
          err_q   <= (syn_d != 3'd0);
          valid_q <= 1'b1;
          // A bit arriving in the decode cycle is the first bit of the next frame.
          if (bus.shift && !bus.frame_clr) begin
            sr_q    <= {6'd0, bus.serial_in};
            cnt_q   <= 3'd1;
            state_q <= RECV;
          end else begin
            cnt_q   <= 3'd0;
            state_q <= IDLE;
          end
        end
        default: begin
          cnt_q   <= 3'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.data_out      = data_q;
  assign bus.syndrome      = syn_q;
  assign bus.err_corrected = err_q;
  assign bus.valid         = valid_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_hamming_serial_receiver.sv
// Bench for hamming_serial_receiver: one correcting and one report-only instance share stimulus.
module tb_hamming_serial_receiver;

  logic clk = 1'b0;
  logic stp_reset;

  hamming_serial_receiver_if b0 ();
  hamming_serial_receiver_if b1 ();

  assign b1.shift     = b0.shift;
  assign b1.serial_in = b0.serial_in;
  assign b1.frame_clr = b0.frame_clr;

  hamming_serial_receiver #(.CORRECT_EN(1'b1)) dut0 (.clk(clk), .stp_reset(stp_reset), .bus(b0.slave));
  hamming_serial_receiver #(.CORRECT_EN(1'b0)) dut1 (.clk(clk), .stp_reset(stp_reset), .bus(b1.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcnt0  = 0;
  int vcnt1  = 0;

  // Counts valid cycles; reads the pre-edge value so it never races the negedge sampling.
  always @(posedge clk) begin
    if (b0.valid === 1'b1) vcnt0++;
    if (b1.valid === 1'b1) vcnt1++;
  end

  typedef struct packed {
    logic [3:0] d;
    logic [2:0] s;
    logic       e;
  } exp_t;

  typedef struct packed {
    logic       vdec0, vdec1, bdec;
    logic       v0, v1;
    logic [3:0] d0, d1;
    logic [2:0] s0, s1;
    logic       e0, e1;
    logic       vaft0, vaft1, baft;
  } obs_t;

  // Reference: the syndrome of a Hamming code is the XOR of the positions of all set bits.
  function automatic exp_t model(input logic [6:0] cw, input bit corr);
    exp_t       r;
    logic [6:0] w;
    int         s;
    s = 0;
    for (int p = 1; p <= 7; p++) if (cw[p-1]) s = s ^ p;
    w = cw;
    if (corr && s != 0) w[s-1] = ~w[s-1];
    r.d = {w[6], w[5], w[4], w[2]};
    r.s = s[2:0];
    r.e = (s != 0);
    return r;
  endfunction

  task automatic send_bits(input logic [6:0] cw, input int mingap, input int maxgap);
    for (int i = 0; i < 7; i++) begin
      b0.shift     = 1'b1;
      b0.serial_in = cw[i];
      @(negedge clk);
      b0.shift     = 1'b0;
      b0.serial_in = 1'($urandom_range(1, 0));
      if (i < 6 && maxgap > 0) repeat ($urandom_range(maxgap, mingap)) @(negedge clk);
    end
  endtask

  task automatic observe(output obs_t o);
    o.vdec0 = b0.valid; o.vdec1 = b1.valid; o.bdec = b0.busy;
    @(negedge clk);
    o.v0 = b0.valid; o.v1 = b1.valid;
    o.d0 = b0.data_out; o.s0 = b0.syndrome; o.e0 = b0.err_corrected;
    o.d1 = b1.data_out; o.s1 = b1.syndrome; o.e1 = b1.err_corrected;
    @(negedge clk);
    o.vaft0 = b0.valid; o.vaft1 = b1.valid; o.baft = b0.busy;
  endtask

  task automatic test_reset();
    stp_reset = 1'b1; b0.shift = 1'b0; b0.serial_in = 1'b0; b0.frame_clr = 1'b0;
    #1;
    checks++; if ({b0.data_out, b0.syndrome, b0.err_corrected, b0.valid, b0.busy} !== 10'd0) begin
      errors++; $display("FAIL reset_dut0: got %b expected 0", {b0.data_out, b0.syndrome, b0.err_corrected, b0.valid, b0.busy}); end
    checks++; if ({b1.data_out, b1.syndrome, b1.err_corrected, b1.valid, b1.busy} !== 10'd0) begin
      errors++; $display("FAIL reset_dut1: got %b expected 0", {b1.data_out, b1.syndrome, b1.err_corrected, b1.valid, b1.busy}); end
    @(negedge clk); stp_reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (b0.busy !== 1'b0 || vcnt0 !== 0) begin
      errors++; $display("FAIL idle_after_reset: busy=%b valids=%0d expected 0/0", b0.busy, vcnt0); end
  endtask

  task automatic test_known_vectors();
    obs_t o;
    send_bits(7'h55, 0, 0);
    observe(o);
    checks++; if (o.vdec0 !== 1'b0 || o.bdec !== 1'b1) begin
      errors++; $display("FAIL k55_latency: valid=%b busy=%b expected 0/1", o.vdec0, o.bdec); end
    checks++; if ({o.v0, o.d0, o.s0, o.e0} !== {1'b1, 4'b1011, 3'b000, 1'b0}) begin
      errors++; $display("FAIL k55_dut0: got %b expected 1_1011_000_0", {o.v0, o.d0, o.s0, o.e0}); end
    checks++; if ({o.v1, o.d1, o.s1, o.e1} !== {1'b1, 4'b1011, 3'b000, 1'b0}) begin
      errors++; $display("FAIL k55_dut1: got %b expected 1_1011_000_0", {o.v1, o.d1, o.s1, o.e1}); end
    checks++; if (o.vaft0 !== 1'b0 || o.baft !== 1'b0) begin
      errors++; $display("FAIL k55_pulse: valid=%b busy=%b expected 0/0", o.vaft0, o.baft); end
    send_bits(7'h45, 0, 0);
    observe(o);
    checks++; if ({o.v0, o.d0, o.s0, o.e0} !== {1'b1, 4'b1011, 3'b101, 1'b1}) begin
      errors++; $display("FAIL k45_corr: got %b expected 1_1011_101_1", {o.v0, o.d0, o.s0, o.e0}); end
    checks++; if ({o.v1, o.d1, o.s1, o.e1} !== {1'b1, 4'b1001, 3'b101, 1'b1}) begin
      errors++; $display("FAIL k45_raw: got %b expected 1_1001_101_1", {o.v1, o.d1, o.s1, o.e1}); end
  endtask

  task automatic test_random_frames();
    obs_t       o;
    exp_t       e0, e1;
    logic [6:0] cw;
    for (int n = 0; n < 24; n++) begin
      cw = 7'($urandom);
      e0 = model(cw, 1'b1);
      e1 = model(cw, 1'b0);
      send_bits(cw, 0, 2);
      observe(o);
      checks++; if (o.vdec0 !== 1'b0 || o.v0 !== 1'b1 || o.v1 !== 1'b1 || o.vaft0 !== 1'b0 || o.vaft1 !== 1'b0) begin
        errors++; $display("FAIL rnd_valid cw=%h: got %b%b%b%b%b expected 01100", cw, o.vdec0, o.v0, o.v1, o.vaft0, o.vaft1); end
      checks++; if ({o.d0, o.s0, o.e0} !== e0) begin
        errors++; $display("FAIL rnd_corr cw=%h: got %b expected %b", cw, {o.d0, o.s0, o.e0}, e0); end
      checks++; if ({o.d1, o.s1, o.e1} !== e1) begin
        errors++; $display("FAIL rnd_raw cw=%h: got %b expected %b", cw, {o.d1, o.s1, o.e1}, e1); end
    end
  endtask

  task automatic test_gaps();
    obs_t o;
    int   vb;
    vb = vcnt0;
    send_bits(7'h55, 1, 3);
    checks++; if (vcnt0 !== vb) begin
      errors++; $display("FAIL gap_early_valid: got %0d pulses expected %0d", vcnt0, vb); end
    observe(o);
    checks++; if ({o.vdec0, o.v0, o.d0, o.s0, o.e0, o.vaft0} !== {1'b0, 1'b1, 4'b1011, 3'b000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL gap_frame: got %b expected 0_1_1011_000_0_0", {o.vdec0, o.v0, o.d0, o.s0, o.e0, o.vaft0}); end
  endtask

  task automatic test_back_to_back(input logic [6:0] f1, input logic [6:0] f2);
    logic [13:0] stream;
    exp_t        e1, e2;
    logic        vexp;
    stream = {f2, f1};
    e1 = model(f1, 1'b1);
    e2 = model(f2, 1'b1);
    for (int k = 0; k < 16; k++) begin
      if (k >= 1) begin
        vexp = (k == 8 || k == 15);
        checks++; if (b0.valid !== vexp || b1.valid !== vexp) begin
          errors++; $display("FAIL b2b_valid k=%0d: got %b%b expected %b", k, b0.valid, b1.valid, vexp); end
        checks++; if (b0.busy !== (k <= 14)) begin
          errors++; $display("FAIL b2b_busy k=%0d: got %b expected %b", k, b0.busy, (k <= 14)); end
        if (k == 8 || k == 15) begin
          checks++; if ({b0.data_out, b0.syndrome, b0.err_corrected} !== ((k == 8) ? e1 : e2)) begin
            errors++; $display("FAIL b2b_data k=%0d: got %b expected %b", k, {b0.data_out, b0.syndrome, b0.err_corrected}, ((k == 8) ? e1 : e2)); end
        end
      end
      b0.shift     = (k < 14);
      b0.serial_in = (k < 14) ? stream[k] : 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_frame_clr();
    obs_t       o;
    exp_t       e;
    logic [6:0] cw;
    int         vb;
    vb = vcnt0;
    for (int i = 0; i < 4; i++) begin
      b0.shift = 1'b1; b0.serial_in = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    b0.frame_clr = 1'b1; b0.shift = 1'b1; b0.serial_in = 1'b1;
    @(negedge clk);
    b0.frame_clr = 1'b0; b0.shift = 1'b0;
    checks++; if (b0.busy !== 1'b0) begin
      errors++; $display("FAIL clr_idle: busy=%b expected 0", b0.busy); end
    send_bits(7'h55, 0, 1);
    observe(o);
    checks++; if ({o.v0, o.d0} !== {1'b1, 4'b1011} || vcnt0 !== vb + 1) begin
      errors++; $display("FAIL clr_frame: valid=%b data=%b pulses=%0d expected 1/1011/%0d", o.v0, o.d0, vcnt0 - vb, 1); end
    cw = 7'($urandom);
    e  = model(cw, 1'b1);
    send_bits(cw, 0, 0);
    b0.frame_clr = 1'b1; b0.shift = 1'b1; b0.serial_in = 1'b1;
    @(negedge clk);
    b0.frame_clr = 1'b0; b0.shift = 1'b0;
    checks++; if (b0.valid !== 1'b1 || {b0.data_out, b0.syndrome, b0.err_corrected} !== e || b0.busy !== 1'b0) begin
      errors++; $display("FAIL clr_in_decode: valid=%b out=%b busy=%b expected 1/%b/0", b0.valid, {b0.data_out, b0.syndrome, b0.err_corrected}, b0.busy, e); end
    @(negedge clk);
    checks++; if (b0.valid !== 1'b0 || b0.busy !== 1'b0) begin
      errors++; $display("FAIL clr_after_decode: valid=%b busy=%b expected 0/0", b0.valid, b0.busy); end
  endtask

  task automatic test_async_reset();
    obs_t o;
    int   vb;
    send_bits(7'h55, 0, 0);
    observe(o);
    vb = vcnt0;
    for (int i = 0; i < 5; i++) begin
      b0.shift = 1'b1; b0.serial_in = 1'($urandom_range(1, 0));
      @(negedge clk);
    end
    b0.shift = 1'b0;
    #2 stp_reset = 1'b1;
    #1;
    checks++; if ({b0.data_out, b0.syndrome, b0.err_corrected, b0.valid, b0.busy} !== 10'd0) begin
      errors++; $display("FAIL arst_dut0: got %b expected 0", {b0.data_out, b0.syndrome, b0.err_corrected, b0.valid, b0.busy}); end
    checks++; if ({b1.data_out, b1.syndrome, b1.err_corrected, b1.valid, b1.busy} !== 10'd0) begin
      errors++; $display("FAIL arst_dut1: got %b expected 0", {b1.data_out, b1.syndrome, b1.err_corrected, b1.valid, b1.busy}); end
    #1 stp_reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (vcnt0 !== vb || b0.busy !== 1'b0) begin
      errors++; $display("FAIL arst_discard: pulses=%0d busy=%b expected %0d/0", vcnt0, b0.busy, vb); end
    send_bits(7'h45, 0, 0);
    observe(o);
    checks++; if ({o.v0, o.d0, o.s0, o.e0} !== {1'b1, 4'b1011, 3'b101, 1'b1}) begin
      errors++; $display("FAIL arst_next_frame: got %b expected 1_1011_101_1", {o.v0, o.d0, o.s0, o.e0}); end
  endtask

  initial begin
    test_reset();
    test_known_vectors();
    test_random_frames();
    test_gaps();
    test_back_to_back(7'h55, 7'h00);
    test_back_to_back(7'($urandom), 7'($urandom));
    test_frame_clr();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
